// File: rtl/sel_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sel_pipe_pkg
// Shared constants and helpers for the operand select pipeline stage.
//   clog2 / sel_width : size of the encoded select for a given input count.
//   entry_* helpers   : layout of a stored entry, packed as {err, src, data}.
//   SEL_ERR_DEFAULT_IDX : input routed to the output when the select is out
//                         of range (the entry is then tagged err=1).
// -----------------------------------------------------------------------------
package sel_pipe_pkg;

    localparam int SEL_ERR_DEFAULT_IDX = 0;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Select width never drops below one bit, even for tiny input counts.
    function automatic int sel_width(input int num_in);
        int w;
        w = clog2(num_in);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Total bits of one entry: data + src + err.
    function automatic int entry_width(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

    // Bit position of the err flag within an entry.
    function automatic int entry_err_bit(input int width, input int sel_w);
        return width + sel_w;
    endfunction

endpackage

// File: rtl/sel_pipe_stage_skid_reg2.sv
// -----------------------------------------------------------------------------
// skid_reg2
// Generic two-entry valid/ready register slice over an opaque payload.
// The main register drives the outputs; the skid register catches the entry
// accepted while the main register is stalled, so in_ready can come from a
// flop instead of from out_ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of both valid flags
//   in_valid/in_ready     upstream handshake (in_ready forced low on flush)
//   in_payload            entry to store
//   out_valid/out_ready   downstream handshake
//   out_payload           entry held in the main register
// -----------------------------------------------------------------------------
module skid_reg2 #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 out_ready
);

    logic                 main_valid_q;
    logic                 main_valid_d;
    logic                 skid_valid_q;
    logic                 skid_valid_d;
    logic                 in_ready_q;
    logic                 in_ready_d;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] main_d;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [PAYLOAD_W-1:0] skid_d;
    logic                 accept_s;
    logic                 xfer_s;

    // Next-state for the two entry slots; flush overrides every other case.
    always_comb begin
        accept_s     = in_valid & in_ready_q & ~flush;
        xfer_s       = main_valid_q & out_ready;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;

        if (flush) begin
            // Only the valid flags clear; payload flops keep stale contents.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (accept_s) begin
                        main_d       = in_payload;
                        main_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (accept_s && xfer_s) begin
                        // Pass-through: occupancy stays at one.
                        main_d = in_payload;
                    end else if (accept_s) begin
                        skid_d       = in_payload;
                        skid_valid_d = 1'b1;
                    end else if (xfer_s) begin
                        main_valid_d = 1'b0;
                    end else begin
                        main_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    // in_ready_q is low here, so no accept can collide.
                    if (xfer_s) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    // Skid full with main empty is unreachable; recover empty.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end

        in_ready_d = ~skid_valid_d;
    end

    // State registers; reset leaves the slice empty and ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_q       <= {PAYLOAD_W{1'b0}};
            skid_q       <= {PAYLOAD_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready    = in_ready_q & ~flush;
    assign out_valid   = main_valid_q;
    assign out_payload = main_q;

endmodule

// File: rtl/sel_pipe_stage.sv
// -----------------------------------------------------------------------------
// sel_pipe_stage
// N-way operand select with a registered, back-pressurable output.
// An encoded select picks one of NUM_IN packed inputs; out-of-range selects
// route input SEL_ERR_DEFAULT_IDX and tag the entry with err. Entries are
// held in a two-entry skid slice so one transfer per cycle survives stalls.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data              NUM_IN*WIDTH packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel               encoded select, sampled on accept
//   in_valid/in_ready    upstream handshake
//   flush                synchronous squash of all held entries
//   out_data/out_src/out_err  registered selected data, its select, range error
//   out_valid/out_ready  downstream handshake
// -----------------------------------------------------------------------------
module sel_pipe_stage
    import sel_pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int ENTRY_W = entry_width(WIDTH, SEL_W);

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] src;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_err_s;
    entry_t           in_entry_s;
    entry_t           out_entry_s;
    logic [ENTRY_W-1:0] in_payload_s;
    logic [ENTRY_W-1:0] out_payload_s;

    // Select mux: a linear compare keeps non-power-of-two counts safe, and
    // any select without a match falls back to the default input with err.
    always_comb begin
        sel_data_s = in_data[SEL_ERR_DEFAULT_IDX*WIDTH +: WIDTH];
        sel_err_s  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data_s = in_data[k*WIDTH +: WIDTH];
                sel_err_s  = 1'b0;
            end else begin
                sel_err_s = sel_err_s;
            end
        end
    end

    // Entry packing into the opaque payload of the skid slice.
    always_comb begin
        in_entry_s.err  = sel_err_s;
        in_entry_s.src  = in_sel;
        in_entry_s.data = sel_data_s;
        in_payload_s    = in_entry_s;
        out_entry_s     = out_payload_s;
    end

    skid_reg2 #(
        .PAYLOAD_W (ENTRY_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload_s),
        .out_valid   (out_valid),
        .out_payload (out_payload_s),
        .out_ready   (out_ready)
    );

    // Outputs come straight from the main register of the slice.
    assign out_data = out_entry_s.data;
    assign out_src  = out_entry_s.src;
    assign out_err  = out_entry_s.err;

endmodule

// File: tb/tb_sel_pipe_stage.sv
module tb_sel_pipe_stage;

    logic clk;
    logic rst_n;

    // DUT A: WIDTH=32, NUM_IN=4
    logic [127:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_v, a_rdy, a_fl, a_ov, a_ordy, a_err;
    logic [31:0]  a_odata;
    logic [1:0]   a_osrc;

    // DUT B: WIDTH=16, NUM_IN=3 (select 3 is out of range)
    logic [47:0]  b_in_data;
    logic [1:0]   b_sel;
    logic         b_v, b_rdy, b_fl, b_ov, b_ordy, b_err;
    logic [15:0]  b_odata;
    logic [1:0]   b_osrc;

    int n_vec = 0;
    int n_err = 0;

    sel_pipe_stage #(.WIDTH(32), .NUM_IN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_sel),
        .in_valid(a_v), .in_ready(a_rdy), .flush(a_fl), .out_data(a_odata),
        .out_src(a_osrc), .out_err(a_err), .out_valid(a_ov), .out_ready(a_ordy)
    );

    sel_pipe_stage #(.WIDTH(16), .NUM_IN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_sel),
        .in_valid(b_v), .in_ready(b_rdy), .flush(b_fl), .out_data(b_odata),
        .out_src(b_osrc), .out_err(b_err), .out_valid(b_ov), .out_ready(b_ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_data;
        logic [1:0]  e_src;
    } row_t;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  s;
        logic        e;
    } ent_t;

    row_t tbl[17];
    ent_t q[$];

    initial begin
        // inputs applied at negedge; expectations are the state seen at that negedge
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 2'd0};
        tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 2'd1};
        tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 2'd2};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 2'd3};
        // back-pressure: A (sel1) then B (sel2)
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 2'd1};
        tbl[7]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22, 2'd1};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22, 2'd1};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 2'd2};
        // flush with both entries held and in_valid high
        tbl[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        tbl[11] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 2'd0};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 2'd0};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        tbl[14] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        tbl[15] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 2'd1};
        tbl[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};

        // ---------------- reset with handshakes active ----------------
        rst_n = 1'b0;
        a_in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        a_sel = 2'd1; a_v = 1'b1; a_fl = 1'b0; a_ordy = 1'b1;
        b_in_data = {16'h3333, 16'h2222, 16'hDEAD};
        b_sel = 2'd2; b_v = 1'b1; b_fl = 1'b0; b_ordy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a_ov",   {31'd0, a_ov}, 32'd0);
        chk("rst_a_data", a_odata, 32'd0);
        chk("rst_a_src",  {30'd0, a_osrc}, 32'd0);
        chk("rst_a_err",  {31'd0, a_err}, 32'd0);
        chk("rst_b_ov",   {31'd0, b_ov}, 32'd0);
        chk("rst_b_data", {16'd0, b_odata}, 32'd0);
        rst_n = 1'b1;
        a_v = 1'b0;
        b_v = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_a_rdy", {31'd0, a_rdy}, 32'd1);
        chk("post_rst_b_rdy", {31'd0, b_rdy}, 32'd1);
        chk("post_rst_a_ov",  {31'd0, a_ov}, 32'd0);

        // ---------------- table-driven directed sequence on DUT A ----------------
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a_v = tbl[i].v; a_sel = tbl[i].sel; a_ordy = tbl[i].ordy; a_fl = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_rdy", i), {31'd0, a_rdy}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_ov", i),  {31'd0, a_ov},  {31'd0, tbl[i].e_ov});
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_data", i), a_odata, tbl[i].e_data);
                chk($sformatf("tbl%0d_src", i),  {30'd0, a_osrc}, {30'd0, tbl[i].e_src});
                chk($sformatf("tbl%0d_err", i),  {31'd0, a_err}, 32'd0);
            end
        end
        a_v = 1'b0; a_fl = 1'b0;

        // ---------------- invalid select on DUT B ----------------
        @(negedge clk);
        b_sel = 2'd3; b_v = 1'b1; b_ordy = 1'b1;
        @(negedge clk);
        b_sel = 2'd2; b_v = 1'b1;
        #1;
        chk("inv_ov",   {31'd0, b_ov}, 32'd1);
        chk("inv_data", {16'd0, b_odata}, 32'h0000DEAD);
        chk("inv_src",  {30'd0, b_osrc}, 32'd3);
        chk("inv_err",  {31'd0, b_err}, 32'd1);
        @(negedge clk);
        b_v = 1'b0;
        #1;
        chk("sel2_data", {16'd0, b_odata}, 32'h00003333);
        chk("sel2_src",  {30'd0, b_osrc}, 32'd2);
        chk("sel2_err",  {31'd0, b_err}, 32'd0);
        @(negedge clk);
        #1;
        chk("drain_ov", {31'd0, b_ov}, 32'd0);

        // ---------------- random soak on DUT B against a FIFO model ----------------
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic [15:0] w [3];
            ent_t ent;
            logic exp_rdy, acc, xf;
            @(negedge clk);
            chk("soak_ov", {31'd0, b_ov}, {31'd0, (q.size() > 0)});
            if (q.size() > 0) begin
                chk("soak_data", {16'd0, b_odata}, {16'd0, q[0].d});
                chk("soak_src",  {30'd0, b_osrc},  {30'd0, q[0].s});
                chk("soak_err",  {31'd0, b_err},   {31'd0, q[0].e});
            end
            b_in_data = {$urandom, $urandom};
            b_sel  = 2'($urandom_range(0, 3));
            b_v    = ($urandom_range(0, 3) != 0);
            b_ordy = (c % 512 < 256) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            b_fl   = ($urandom_range(0, 39) == 0);
            #1;
            exp_rdy = !b_fl && (q.size() < 2);
            chk("soak_rdy", {31'd0, b_rdy}, {31'd0, exp_rdy});
            w[0] = b_in_data[15:0];
            w[1] = b_in_data[31:16];
            w[2] = b_in_data[47:32];
            ent.s = b_sel;
            if (b_sel < 2'd3) begin
                ent.d = w[b_sel];
                ent.e = 1'b0;
            end else begin
                ent.d = w[0];
                ent.e = 1'b1;
            end
            acc = b_v && exp_rdy;
            xf  = (q.size() > 0) && b_ordy;
            if (b_fl) begin
                q.delete();
            end else begin
                if (xf) void'(q.pop_front());
                if (acc) q.push_back(ent);
            end
        end

        // ---------------- reset while entries are held ----------------
        @(negedge clk);
        b_fl = 1'b0; b_ordy = 1'b0; b_v = 1'b1; b_sel = 2'd1;
        b_in_data = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        repeat (2) @(negedge clk);
        b_v = 1'b0;
        #1;
        chk("pre_rst_ov", {31'd0, b_ov}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov",   {31'd0, b_ov}, 32'd0);
        chk("mid_rst_data", {16'd0, b_odata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b_ordy = 1'b1;
        @(negedge clk);
        #1;
        chk("after_rst_ov",  {31'd0, b_ov}, 32'd0);
        chk("after_rst_rdy", {31'd0, b_rdy}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sel_pipe_stage.md
# sel_pipe_stage

Parametrised N-way, W-bit operand select stage with a registered output and a valid/ready handshake, used between pipeline stages wherever a plain select mux must also absorb back-pressure (forwarding paths, write-back source select, register-address select). It selects one of `NUM_IN` packed inputs by an encoded select and registers the result. A 2-entry skid buffer sustains one transfer per cycle under stalls, and a synchronous flush squashes in-flight data on branch/exception.

## Interface
- `WIDTH`, 32, data width per input (≥1).
- `NUM_IN`, 4, number of selectable inputs (2..16; need not be a power of two).
- `SEL_W`, derived localparam = max(1, clog2(NUM_IN)); not overridable.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- `in_sel`  in  SEL_W  encoded select, sampled on accept.
- `in_valid`  in  1  upstream has a request.
- `in_ready`  out  1  stage can accept this cycle.
- `flush`  in  1  synchronous squash of all held entries.
- `out_data`  out  WIDTH  selected, registered data.
- `out_src`  out  SEL_W  select value that produced `out_data`.
- `out_err`  out  1  high with an entry whose select was ≥ NUM_IN.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accepts.

## Operation
- Accept = `in_valid & in_ready`; output transfer = `out_valid & out_ready`.
- Select: `in_sel` < NUM_IN picks that input. `in_sel` ≥ NUM_IN picks input 0 and tags the entry with err=1. Entry = {data, src=in_sel, err}.
- Storage: main register (drives outputs) plus one skid register; `in_ready` = !skid_valid, driven from a flop (no combinational path from `out_ready`).
- On accept:
  - Main empty, or main transferring this cycle with skid empty: entry loads into main.
  - Otherwise: entry loads into skid.
- On transfer with skid full: skid moves to main and skid empties; in_ready rises next cycle.
- Accept and transfer in the same cycle: one entry out, one in; occupancy is unchanged.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush.
- `flush` has priority over everything:
  - Next cycle, main_valid = skid_valid = 0.
  - `in_ready` is forced 0 during the flush cycle, so no accept occurs.
  - A transfer in the flush cycle still counts as consumed.
  - Data/src/err registers keep stale values; only the valid flags clear.
- Reset (asynchronous, rst_n low): out_valid=0, out_data=0, out_src=0, out_err=0, skid_valid=0, skid contents=0, in_ready=1 once rst_n is high. Handshakes while rst_n is low are ignored. Reset mid-transfer discards all entries.

## Timing
- Latency: accept in cycle t → out_valid=1 with that entry in cycle t+1 (empty stage).
- Throughput: 1 entry/cycle with out_ready held high.
- Capacity: 2 entries. With out_ready low, the stage accepts 2 entries; in_ready is 0 from the cycle after the second accept.
- After out_ready rises with both entries full:
  - Main transfers; skid → main next cycle.
  - in_ready=1 in that same next cycle.
- All outputs are flop-driven. in_sel/in_data → outputs is one register stage; there is no combinational input→output path.

## Structure
- Package `sel_pipe_pkg`:
  - `clog2` helper function.
  - Entry struct/bit layout {err, src, data}, with width computed from WIDTH/SEL_W.
  - Constant `SEL_ERR_DEFAULT_IDX = 0`.
- Sub-module `skid_reg2`:
  - Generic 2-entry valid/ready skid register over an opaque payload of width (WIDTH+SEL_W+1), with flush.
  - `sel_pipe_stage` instantiates the combinational select/err logic in front of it.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, out_data=0, out_src=0, out_err=0. First cycle after release → in_ready=1.
- Streaming, WIDTH=32, NUM_IN=4: inputs {0x11,0x22,0x33,0x44}, in_sel=0,1,2,3 on successive cycles, out_ready=1 → out_data 0x11,0x22,0x33,0x44 on cycles t+1..t+4, out_src 0..3, out_err=0.
- Back-pressure: out_ready=0, present A then B → both accepted, in_ready=0 on the third cycle. Raise out_ready → A then B on consecutive cycles, in_ready=1 the cycle after A leaves.
- Invalid select, NUM_IN=3: in_sel=3 with input0=0xDEAD → out_data=0xDEAD, out_src=3, out_err=1.
- Flush with both entries held plus in_valid=1 → in_ready=0 that cycle. Next cycle out_valid=0, and no flushed value ever appears.
- Random valid/ready soak (10k cycles) → output sequence equals accepted sequence exactly, with no loss or duplication.
